// File: rtl/membus_pkg.sv
// membus_pkg: word width, port-monitor state type and flat-array index
// helpers shared by membus_hub and membus_port_mon.
package membus_pkg;

    localparam int MBW = 36;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_RS   = 2'd2,
        ST_WAIT_DROP = 2'd3
    } mon_state_t;

    // Module m, port p lives at m*nport+p in the flat response arrays.
    function automatic int flat_idx(input int m, input int p, input int nport);
        return m * nport + p;
    endfunction

    function automatic int word_lsb(input int idx);
        return idx * MBW;
    endfunction

endpackage

// File: rtl/membus_port_mon.sv
// membus_port_mon: one processor port's cycle monitor -- gates module responses,
// flags multi-module acks, optionally times out cycles (MEMBUS_NXM_EN).
// Ports: clk, reset (sync, active-high); i_rq_cyc, i_rd_rq from processor;
// i_acks/i_rss per-module responses; o_addr_ack, o_rd_rs, o_nxm, o_busy,
// o_conflict to processor.
module membus_port_mon
    import membus_pkg::*;
#(
    parameter int NMEM       = 2,
    parameter int NXM_CYCLES = 1000,
    parameter int CW         = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_rq_cyc,
    input  logic            i_rd_rq,
    input  logic [NMEM-1:0] i_acks,
    input  logic [NMEM-1:0] i_rss,
    output logic            o_addr_ack,
    output logic            o_rd_rs,
    output logic            o_nxm,
    output logic            o_busy,
    output logic            o_conflict
);

    mon_state_t r_state;
    mon_state_t w_state_nxt;
    mon_state_t w_after_ack;
    logic       r_conflict;
    logic       w_ack_any;
    logic       w_rs_any;
    logic       w_multi;
    logic       w_ack;
    logic       w_rs;
    logic       w_nxm;
    logic       w_tmo;
    logic       w_syn_rs;

    assign w_ack_any   = |i_acks;
    assign w_rs_any    = |i_rss;
    // Clearing the lowest set bit leaves something only if two were set.
    assign w_multi     = |(i_acks & (i_acks - NMEM'(1)));
    assign w_after_ack = i_rd_rq ? ST_WAIT_RS : ST_WAIT_DROP;

`ifdef MEMBUS_NXM_EN
    logic [CW-1:0] r_cnt;
    logic          r_syn_rs;

    assign w_tmo    = (r_cnt == CW'(NXM_CYCLES - 1));
    assign w_syn_rs = r_syn_rs;

    // Counter restarts on every state change, so it times each wait phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_syn_rs <= 1'b0;
        end else begin
            if (w_state_nxt != r_state || r_state == ST_IDLE ||
                r_state == ST_WAIT_DROP)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            // A timed-out read gets its restart on the very next clock.
            r_syn_rs <= w_nxm && (w_state_nxt == ST_WAIT_RS);
        end
    end
`else
    localparam int unused_cfg = NXM_CYCLES + CW;
    assign w_tmo    = 1'b0;
    assign w_syn_rs = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_rs        = 1'b0;
        w_nxm       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_rq_cyc) begin
                    w_ack = w_ack_any;
                    if (w_ack_any)
                        w_state_nxt = w_after_ack;
                    else
                        w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                w_ack = w_ack_any;
                if (!i_rq_cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ack_any) begin
                    w_state_nxt = w_after_ack;
                end else if (w_tmo) begin
                    w_ack       = 1'b1;
                    w_nxm       = 1'b1;
                    w_state_nxt = w_after_ack;
                end
            end
            ST_WAIT_RS: begin
                w_rs = w_rs_any;
                if (!i_rq_cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rs_any) begin
                    w_state_nxt = ST_WAIT_DROP;
                end else if (w_syn_rs || w_tmo) begin
                    w_rs        = 1'b1;
                    w_nxm       = !w_syn_rs;
                    w_state_nxt = ST_WAIT_DROP;
                end
            end
            ST_WAIT_DROP: begin
                if (!i_rq_cyc)
                    w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_conflict <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_multi)
                r_conflict <= 1'b1;
        end
    end

    assign o_addr_ack = w_ack & ~reset;
    assign o_rd_rs    = w_rs & ~reset;
    assign o_nxm      = w_nxm & ~reset;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_conflict = r_conflict;

endmodule

// File: rtl/membus_hub.sv
// membus_hub: joins NPORT processor ports to NMEM memory modules; ORs module
// data/acks/restarts per port and runs one membus_port_mon per port.
// Ports: clk, reset; p_* processor side (NPORT bits / 36-bit words);
// m_* module side flat arrays indexed m*NPORT+p. Option: MEMBUS_NXM_EN.
module membus_hub
    import membus_pkg::*;
#(
    parameter int NMEM       = 2,
    parameter int NPORT      = 1,
    parameter int NXM_CYCLES = 1000,
    parameter int CW         = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NPORT-1:0]            p_rq_cyc,
    input  logic [NPORT-1:0]            p_rd_rq,
    input  logic [NPORT-1:0]            p_wr_rq,
    input  logic [MBW*NPORT-1:0]        p_mb_out,
    output logic [MBW*NPORT-1:0]        p_mb_in,
    output logic [NPORT-1:0]            p_addr_ack,
    output logic [NPORT-1:0]            p_rd_rs,
    output logic [NPORT-1:0]            p_nxm,
    output logic [NPORT-1:0]            p_busy,
    output logic [NPORT-1:0]            p_conflict,
    input  logic [NMEM*NPORT-1:0]       m_addr_ack,
    input  logic [NMEM*NPORT-1:0]       m_rd_rs,
    input  logic [MBW*NMEM*NPORT-1:0]   m_mb_out
);

    // Writes and read-modify-writes differ only by rd_rq.
    logic unused_wr;
    assign unused_wr = ^p_wr_rq;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [NMEM-1:0]          w_acks;
        logic [NMEM-1:0]          w_rss;
        logic [NMEM:0][MBW-1:0]   w_or;

        assign w_or[0] = p_mb_out[word_lsb(p) +: MBW];

        for (genvar m = 0; m < NMEM; m++) begin : g_mem
            localparam int IDX = flat_idx(m, p, NPORT);
            assign w_acks[m]  = m_addr_ack[IDX];
            assign w_rss[m]   = m_rd_rs[IDX];
            assign w_or[m+1]  = w_or[m] | m_mb_out[word_lsb(IDX) +: MBW];
        end

        assign p_mb_in[word_lsb(p) +: MBW] = w_or[NMEM];

        membus_port_mon #(
            .NMEM       (NMEM),
            .NXM_CYCLES (NXM_CYCLES),
            .CW         (CW)
        ) u_mon (
            .clk        (clk),
            .reset      (reset),
            .i_rq_cyc   (p_rq_cyc[p]),
            .i_rd_rq    (p_rd_rq[p]),
            .i_acks     (w_acks),
            .i_rss      (w_rss),
            .o_addr_ack (p_addr_ack[p]),
            .o_rd_rs    (p_rd_rs[p]),
            .o_nxm      (p_nxm[p]),
            .o_busy     (p_busy[p]),
            .o_conflict (p_conflict[p])
        );
    end

endmodule

// File: tb/tb_membus_hub.sv
// tb_membus_hub: directed and random stimulus for membus_hub (NMEM=2, NPORT=2,
// NXM_CYCLES=8) checked against a timestamp-based transaction model.
module tb_membus_hub;

    localparam int NMEM  = 2;
    localparam int NPORT = 2;
    localparam int NXM   = 8;
    localparam int CW    = 4;
    localparam int W     = 36;
`ifdef MEMBUS_NXM_EN
    localparam bit NXM_EN = 1'b1;
`else
    localparam bit NXM_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NPORT-1:0]         p_rq_cyc, p_rd_rq, p_wr_rq;
    logic [W*NPORT-1:0]       p_mb_out, p_mb_in;
    logic [NPORT-1:0]         p_addr_ack, p_rd_rs, p_nxm, p_busy, p_conflict;
    logic [NMEM*NPORT-1:0]    m_addr_ack, m_rd_rs;
    logic [W*NMEM*NPORT-1:0]  m_mb_out;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // Model: a cycle is open once rq_cyc is seen; timestamps mark when each
    // wait began, timeouts fire at fixed offsets from those marks.
    bit     md_open[NPORT], md_acked[NPORT], md_rsd[NPORT];
    bit     md_read[NPORT], md_nxmpath[NPORT], md_conf[NPORT];
    longint md_mark[NPORT];

    logic [NPORT-1:0] s_ack, s_rs, s_nxm, s_busy, s_conf;
    logic [W-1:0]     s_mb[NPORT];

    membus_hub #(
        .NMEM(NMEM), .NPORT(NPORT), .NXM_CYCLES(NXM), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .p_rq_cyc(p_rq_cyc), .p_rd_rq(p_rd_rq), .p_wr_rq(p_wr_rq),
        .p_mb_out(p_mb_out), .p_mb_in(p_mb_in),
        .p_addr_ack(p_addr_ack), .p_rd_rs(p_rd_rs), .p_nxm(p_nxm),
        .p_busy(p_busy), .p_conflict(p_conflict),
        .m_addr_ack(m_addr_ack), .m_rd_rs(m_rd_rs), .m_mb_out(m_mb_out)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs,
                        input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd36();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic int n_ack(input int p);
        int n = 0;
        for (int m = 0; m < NMEM; m++) n += int'(m_addr_ack[m*NPORT+p]);
        return n;
    endfunction

    function automatic bit any_rs(input int p);
        bit r = 0;
        for (int m = 0; m < NMEM; m++) r |= m_rd_rs[m*NPORT+p];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_mb(input int p);
        logic [W-1:0] r;
        r = p_mb_out[p*W +: W];
        for (int m = 0; m < NMEM; m++) r |= m_mb_out[(m*NPORT+p)*W +: W];
        return r;
    endfunction

    function automatic bit tmo_ack(input int p);
        return NXM_EN && md_open[p] && !md_acked[p] && p_rq_cyc[p] &&
               (cyc == md_mark[p] + NXM);
    endfunction

    function automatic bit tmo_rs(input int p);
        return NXM_EN && md_open[p] && md_acked[p] && md_read[p] &&
               !md_rsd[p] && p_rq_cyc[p] &&
               (cyc == md_mark[p] + (md_nxmpath[p] ? 1 : NXM));
    endfunction

    function automatic void advance();
        for (int p = 0; p < NPORT; p++) begin
            bit aa, ar, ta, tr;
            aa = n_ack(p) > 0;
            ar = any_rs(p);
            ta = tmo_ack(p);
            tr = tmo_rs(p);
            if (reset) begin
                md_open[p] = 0; md_acked[p] = 0; md_rsd[p] = 0;
                md_read[p] = 0; md_nxmpath[p] = 0; md_conf[p] = 0;
            end else begin
                if (n_ack(p) >= 2) md_conf[p] = 1;
                if (!md_open[p]) begin
                    if (p_rq_cyc[p]) begin
                        md_open[p] = 1;
                        md_mark[p] = cyc;
                        if (aa) begin
                            md_acked[p] = 1;
                            md_read[p]  = p_rd_rq[p];
                        end
                    end
                end else if (!p_rq_cyc[p]) begin
                    md_open[p] = 0; md_acked[p] = 0; md_rsd[p] = 0;
                    md_read[p] = 0; md_nxmpath[p] = 0;
                end else if (!md_acked[p]) begin
                    if (aa || ta) begin
                        md_acked[p]   = 1;
                        md_read[p]    = p_rd_rq[p];
                        md_mark[p]    = cyc;
                        md_nxmpath[p] = !aa;
                    end
                end else if (md_read[p] && !md_rsd[p] && (ar || tr)) begin
                    md_rsd[p] = 1;
                end
            end
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        for (int p = 0; p < NPORT; p++) begin
            bit aa, ar, ta, tr, ea, er, en;
            aa = n_ack(p) > 0;
            ar = any_rs(p);
            ta = tmo_ack(p);
            tr = tmo_rs(p);
            ea = !reset && ((!md_open[p] && p_rq_cyc[p] && aa) ||
                            (md_open[p] && !md_acked[p] && (aa || ta)));
            er = !reset && md_open[p] && md_acked[p] && md_read[p] &&
                 !md_rsd[p] && (ar || tr);
            en = !reset && ((ta && !aa) || (tr && !md_nxmpath[p] && !ar));
            s_ack[p]  = p_addr_ack[p];
            s_rs[p]   = p_rd_rs[p];
            s_nxm[p]  = p_nxm[p];
            s_busy[p] = p_busy[p];
            s_conf[p] = p_conflict[p];
            s_mb[p]   = p_mb_in[p*W +: W];
            chk1($sformatf("ack[%0d]@%0d", p, cyc), s_ack[p], ea);
            chk1($sformatf("rs[%0d]@%0d", p, cyc), s_rs[p], er);
            chk1($sformatf("nxm[%0d]@%0d", p, cyc), s_nxm[p], en);
            chk1($sformatf("busy[%0d]@%0d", p, cyc), s_busy[p], md_open[p]);
            chk1($sformatf("conf[%0d]@%0d", p, cyc), s_conf[p], md_conf[p]);
            chkw($sformatf("mb[%0d]@%0d", p, cyc), s_mb[p], exp_mb(p));
        end
        advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        p_rq_cyc = '0; p_rd_rq = '0; p_wr_rq = '0; p_mb_out = '0;
        m_addr_ack = '0; m_rd_rs = '0; m_mb_out = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    logic [W-1:0] dval;
    bit           seen;
    bit           all_busy;
    int           rem_hi[NPORT];
    int           rem_lo[NPORT];

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        chk1("reset_busy0", p_busy[0], 1'b0);
        chk1("reset_ack0", p_addr_ack[0], 1'b0);
        reset = 1'b0;
        tick();

        // Read: module 1 acks at clock 3, restarts with data at clock 6.
        p_rq_cyc[0] = 1'b1; p_rd_rq[0] = 1'b1;
        repeat (3) tick();
        m_addr_ack[2] = 1'b1;
        tick();
        chk1("t1_ack_c3", s_ack[0], 1'b1);
        m_addr_ack[2] = 1'b0;
        repeat (2) tick();
        m_rd_rs[2] = 1'b1;
        m_mb_out[2*W +: W] = 36'o123456701234;
        tick();
        chk1("t1_rs_c6", s_rs[0], 1'b1);
        chkw("t1_data_c6", s_mb[0], 36'o123456701234);
        m_rd_rs[2] = 1'b0; m_mb_out = '0;
        tick();
        chk1("t1_busy_hold", s_busy[0], 1'b1);
        p_rq_cyc[0] = 1'b0; p_rd_rq[0] = 1'b0;
        repeat (2) tick();
        chk1("t1_idle", s_busy[0], 1'b0);

        // Two modules ack port 0 together: sticky conflict.
        do_reset();
        m_addr_ack = 4'b0101;
        tick();
        m_addr_ack = '0;
        tick();
        chk1("t4_conf_set", s_conf[0], 1'b1);
        chk1("t4_conf_p1", s_conf[1], 1'b0);
        p_rq_cyc[0] = 1'b1; p_wr_rq[0] = 1'b1;
        tick();
        m_addr_ack[0] = 1'b1;
        tick();
        m_addr_ack[0] = 1'b0;
        p_rq_cyc[0] = 1'b0; p_wr_rq[0] = 1'b0;
        repeat (3) tick();
        chk1("t4_conf_hold", s_conf[0], 1'b1);
        do_reset();
        tick();
        chk1("t4_conf_clr", s_conf[0], 1'b0);

        // Port 1 reads while port 0 writes; reset lands in port 1's WAIT_RS.
        p_rq_cyc = 2'b11; p_rd_rq = 2'b10; p_wr_rq = 2'b01;
        p_mb_out = {36'o000000000070, 36'o000000000001};
        tick();
        dval = 36'o707070707000;
        m_addr_ack[1] = 1'b1;
        m_mb_out[1*W +: W] = dval;
        tick();
        chk1("t5_ack_p1", s_ack[1], 1'b1);
        chk1("t5_iso_ack_p0", s_ack[0], 1'b0);
        chkw("t5_iso_mb_p0", s_mb[0], 36'o000000000001);
        chkw("t5_mb_p1", s_mb[1], dval | 36'o000000000070);
        m_addr_ack = '0; m_mb_out = '0;
        m_addr_ack[0] = 1'b1;
        tick();
        chk1("t5_ack_p0", s_ack[0], 1'b1);
        m_addr_ack = '0;
        tick();
        reset = 1'b1;
        m_rd_rs[1] = 1'b1;
        tick();
        chk1("t5_rs_in_reset", s_rs[1], 1'b0);
        reset = 1'b0;
        clear_inputs();
        tick();
        chk1("t5_busy0", s_busy[0], 1'b0);
        chk1("t5_busy1", s_busy[1], 1'b0);
        chk1("t5_rs1", s_rs[1], 1'b0);
        chk1("t5_ack1", s_ack[1], 1'b0);

`ifdef MEMBUS_NXM_EN
        // Write, nobody answers.
        do_reset();
        p_rq_cyc[0] = 1'b1; p_wr_rq[0] = 1'b1;
        repeat (NXM) tick();
        tick();
        chk1("t2_ack_c8", s_ack[0], 1'b1);
        chk1("t2_nxm_c8", s_nxm[0], 1'b1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= s_rs[0];
        end
        chk1("t2_no_rs", seen, 1'b0);
        chk1("t2_drop_busy", s_busy[0], 1'b1);
        p_rq_cyc[0] = 1'b0; p_wr_rq[0] = 1'b0;
        repeat (2) tick();
        chk1("t2_idle", s_busy[0], 1'b0);

        // Read, nobody answers; a late ack is suppressed.
        do_reset();
        dval = 36'o135724613572;
        p_rq_cyc[0] = 1'b1; p_rd_rq[0] = 1'b1;
        p_mb_out[0 +: W] = dval;
        repeat (NXM) tick();
        tick();
        chk1("t3_ack_c8", s_ack[0], 1'b1);
        chk1("t3_nxm_c8", s_nxm[0], 1'b1);
        tick();
        chk1("t3_rs_c9", s_rs[0], 1'b1);
        chk1("t3_nxm_c9", s_nxm[0], 1'b0);
        chkw("t3_mb_c9", s_mb[0], dval);
        repeat (2) tick();
        m_addr_ack[0] = 1'b1;
        tick();
        chk1("t3_late_ack", s_ack[0], 1'b0);
        clear_inputs();
        repeat (2) tick();
`else
        // No timeout hardware: the cycle just waits.
        do_reset();
        p_rq_cyc[0] = 1'b1; p_rd_rq[0] = 1'b1;
        tick();
        seen = 0;
        all_busy = 1;
        for (int i = 0; i < 5000; i++) begin
            tick();
            seen |= s_nxm[0] | s_ack[0] | s_rs[0];
            all_busy &= s_busy[0];
        end
        chk1("t6_no_pulse", seen, 1'b0);
        chk1("t6_busy", all_busy, 1'b1);
        clear_inputs();
        repeat (2) tick();
`endif

        // Random traffic on both ports with stray module responses.
        do_reset();
        for (int p = 0; p < NPORT; p++) begin
            rem_hi[p] = 0;
            rem_lo[p] = 0;
        end
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < NPORT; p++) begin
                if (p_rq_cyc[p]) begin
                    if (rem_hi[p] > 0) begin
                        rem_hi[p]--;
                    end else begin
                        p_rq_cyc[p] = 1'b0;
                        rem_lo[p] = int'($urandom_range(0, 3));
                    end
                end else if (rem_lo[p] > 0) begin
                    rem_lo[p]--;
                end else begin
                    int k;
                    k = int'($urandom_range(0, 2));
                    p_rq_cyc[p] = 1'b1;
                    p_rd_rq[p]  = (k != 1);
                    p_wr_rq[p]  = (k != 0);
                    rem_hi[p]   = int'($urandom_range(1, 25));
                    p_mb_out[p*W +: W] = rnd36();
                end
            end
            for (int k = 0; k < NMEM*NPORT; k++) begin
                m_addr_ack[k] = ($urandom_range(0, 9) == 0);
                m_rd_rs[k]    = ($urandom_range(0, 9) == 0);
                m_mb_out[k*W +: W] = rnd36();
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
